// File: rtl/eth_pkg.sv
// Shared constants, header lengths and parser state encoding for the
// nibble-fed Ethernet/IPv4/UDP receive path.
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE       = 8'hD5;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam logic [7:0]  IP_VER_IHL5    = 8'h45;

  localparam int PREAMBLE_LEN = 8;
  localparam int ETH_HEAD_LEN = 14;
  localparam int IP_HEAD_LEN  = 20;
  localparam int UDP_HEAD_LEN = 8;

  localparam logic [15:0] IP_UDP_HDR_BYTES = 16'(IP_HEAD_LEN + UDP_HEAD_LEN);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_ETH_HEAD = 3'd2,
    S_IP_HEAD  = 3'd3,
    S_UDP_HEAD = 3'd4,
    S_RX_DATA  = 3'd5,
    S_REJECT   = 3'd6
  } rx_state_t;

  // Byte idx of a 48-bit field in wire order (idx 0 = most significant byte).
  function automatic logic [7:0] byte_of48(input logic [47:0] v, input logic [2:0] idx);
    logic [47:0] s;
    s = v << {idx, 3'b000};
    return s[47:40];
  endfunction

  function automatic logic [7:0] byte_of32(input logic [31:0] v, input logic [1:0] idx);
    logic [31:0] s;
    s = v << {idx, 3'b000};
    return s[31:24];
  endfunction

endpackage

// File: rtl/nibble_to_byte.sv
// Pairs MII receive nibbles into bytes; the pairing phase restarts whenever
// rxdv is low so every frame starts on a byte boundary.
module nibble_to_byte (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxdv,
  input  logic [3:0] nibble,
  output logic [7:0] rx_byte,
  output logic       byte_valid
);

  logic       toggle_q, toggle_d;
  logic [3:0] low_q, low_d;

  always_comb begin
    toggle_d = rxdv ? ~toggle_q : 1'b0;
    low_d    = (rxdv && !toggle_q) ? nibble : low_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle_q <= 1'b0;
      low_q    <= 4'h0;
    end else begin
      toggle_q <= toggle_d;
      low_q    <= low_d;
    end
  end

  // The byte is presented in the cycle its high nibble is on the pins.
  assign byte_valid = rxdv & toggle_q;
  assign rx_byte    = {nibble, low_q};

endmodule

// File: rtl/ip_udp_rx_nibble.sv
// Ethernet/IPv4/UDP receive parser: filters on MAC/IP, strips headers and
// emits the UDP payload as big-endian 32-bit words.
module ip_udp_rx_nibble
  import eth_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC = 48'h12_34_56_78_9A_BC,
  parameter logic [31:0] BOARD_IP  = {8'd169, 8'd254, 8'd1, 8'd23}
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        eth_rxdv,
  input  logic [3:0]  eth_rx_data,
  output logic        rec_data_en,
  output logic [31:0] rec_data,
  output logic        rec_end,
  output logic [15:0] rec_data_num,
  output logic [2:0]  dbg_state
);

  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0] ETH_LAST = 16'(ETH_HEAD_LEN - 1);
  localparam logic [15:0] IP_LAST  = 16'(IP_HEAD_LEN - 1);
  localparam logic [15:0] UDP_LAST = 16'(UDP_HEAD_LEN - 1);

  logic [7:0]  rx_byte;
  logic        byte_valid;

  rx_state_t   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rxdv_q, rxdv_d;
  logic        mac_me_q, mac_me_d;
  logic        mac_bc_q, mac_bc_d;
  logic        hdr_ok_q, hdr_ok_d;
  logic [15:0] total_len_q, total_len_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rec_data_q, rec_data_d;
  logic [15:0] rec_data_num_q, rec_data_num_d;
  logic        rec_data_en_q, rec_data_en_d;
  logic        rec_end_q, rec_end_d;

  logic        field_ok;
  logic [15:0] cnt_inc;
  logic [15:0] pay_len;
  logic [31:0] lane_word;
  logic [31:0] packed_word;
  logic        last_pay;

  nibble_to_byte u_nibble_to_byte (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .rxdv       (eth_rxdv),
    .nibble     (eth_rx_data),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rxdv_d         = eth_rxdv;
    mac_me_d       = mac_me_q;
    mac_bc_d       = mac_bc_q;
    hdr_ok_d       = hdr_ok_q;
    total_len_d    = total_len_q;
    word_d         = word_q;
    rec_data_d     = rec_data_q;
    rec_data_num_d = rec_data_num_q;
    rec_data_en_d  = 1'b0;
    rec_end_d      = 1'b0;
    field_ok       = 1'b1;
    cnt_inc        = cnt_q + 16'd1;
    pay_len        = total_len_q - IP_UDP_HDR_BYTES;
    // Payload byte k lands in lane k%4; lane 0 starts a fresh, zero-filled word.
    lane_word      = {rx_byte, 24'h000000} >> {cnt_q[1:0], 3'b000};
    packed_word    = (cnt_q[1:0] == 2'd0) ? lane_word : (word_q | lane_word);
    last_pay       = (cnt_inc == rec_data_num_q);

    if (!eth_rxdv) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!rxdv_q) begin
            state_d = S_PREAMBLE;
            cnt_d   = '0;
          end
        end

        S_PREAMBLE: begin
          if (byte_valid) begin
            if (cnt_q == PRE_LAST) begin
              cnt_d = '0;
              if (rx_byte == SFD_BYTE) begin
                state_d  = S_ETH_HEAD;
                mac_me_d = 1'b1;
                mac_bc_d = 1'b1;
                hdr_ok_d = 1'b1;
              end else begin
                state_d = S_REJECT;
              end
            end else if (rx_byte != PREAMBLE_BYTE) begin
              state_d = S_REJECT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end

        S_ETH_HEAD: begin
          if (byte_valid) begin
            if (cnt_q < 16'd6) begin
              mac_me_d = mac_me_q & (rx_byte == byte_of48(BOARD_MAC, cnt_q[2:0]));
              mac_bc_d = mac_bc_q & (rx_byte == 8'hFF);
            end
            if (cnt_q == 16'd12) field_ok = (rx_byte == ETHERTYPE_IPV4[15:8]);
            if (cnt_q == ETH_LAST) field_ok = (rx_byte == ETHERTYPE_IPV4[7:0]);
            hdr_ok_d = hdr_ok_q & field_ok;
            if (cnt_q == ETH_LAST) begin
              cnt_d    = '0;
              state_d  = (hdr_ok_d && (mac_me_q || mac_bc_q)) ? S_IP_HEAD : S_REJECT;
              hdr_ok_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end

        S_IP_HEAD: begin
          if (byte_valid) begin
            case (cnt_q)
              16'd0:  field_ok = (rx_byte == IP_VER_IHL5);
              16'd2:  total_len_d[15:8] = rx_byte;
              16'd3:  total_len_d[7:0]  = rx_byte;
              16'd9:  field_ok = (rx_byte == IP_PROTO_UDP);
              16'd16, 16'd17, 16'd18, 16'd19:
                field_ok = (rx_byte == byte_of32(BOARD_IP, cnt_q[1:0]));
              default: ;
            endcase
            hdr_ok_d = hdr_ok_q & field_ok;
            if (cnt_q == IP_LAST) begin
              cnt_d   = '0;
              state_d = hdr_ok_d ? S_UDP_HEAD : S_REJECT;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end

        S_UDP_HEAD: begin
          if (byte_valid) begin
            if (cnt_q == UDP_LAST) begin
              cnt_d = '0;
              if (total_len_q > IP_UDP_HDR_BYTES) begin
                state_d        = S_RX_DATA;
                rec_data_num_d = pay_len;
              end else begin
                // Empty or malformed datagram: nothing to deliver.
                state_d = S_REJECT;
                if (total_len_q == IP_UDP_HDR_BYTES) rec_data_num_d = '0;
              end
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end

        S_RX_DATA: begin
          if (byte_valid) begin
            word_d = packed_word;
            if (cnt_q[1:0] == 2'd3 || last_pay) begin
              rec_data_en_d = 1'b1;
              rec_data_d    = packed_word;
            end
            if (last_pay) begin
              rec_end_d = 1'b1;
              state_d   = S_REJECT;
              cnt_d     = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end

        S_REJECT: ;

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      // Treat rxdv as already high so a frame in flight at release is skipped.
      rxdv_q         <= 1'b1;
      mac_me_q       <= 1'b0;
      mac_bc_q       <= 1'b0;
      hdr_ok_q       <= 1'b0;
      total_len_q    <= '0;
      word_q         <= '0;
      rec_data_q     <= '0;
      rec_data_num_q <= '0;
      rec_data_en_q  <= 1'b0;
      rec_end_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rxdv_q         <= rxdv_d;
      mac_me_q       <= mac_me_d;
      mac_bc_q       <= mac_bc_d;
      hdr_ok_q       <= hdr_ok_d;
      total_len_q    <= total_len_d;
      word_q         <= word_d;
      rec_data_q     <= rec_data_d;
      rec_data_num_q <= rec_data_num_d;
      rec_data_en_q  <= rec_data_en_d;
      rec_end_q      <= rec_end_d;
    end
  end

  assign rec_data_en  = rec_data_en_q;
  assign rec_data     = rec_data_q;
  assign rec_end      = rec_end_q;
  assign rec_data_num = rec_data_num_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ip_udp_rx_nibble.sv
// Self-checking bench for ip_udp_rx_nibble: table of frames plus abort/reset
// sequences, with payload words checked through an expected queue.
module tb_ip_udp_rx_nibble;

  localparam logic [47:0] BOARD_MAC = 48'h12_34_56_78_9A_BC;
  localparam logic [31:0] BOARD_IP  = {8'd169, 8'd254, 8'd1, 8'd23};
  localparam logic [47:0] SRC_MAC   = 48'h02_00_00_00_00_01;
  localparam logic [31:0] SRC_IP    = {8'd169, 8'd254, 8'd1, 8'd1};
  localparam int          PAY_OFS   = 50;
  localparam int          NV        = 12;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        eth_rxdv;
  logic [3:0]  eth_rx_data;
  logic        rec_data_en;
  logic [31:0] rec_data;
  logic        rec_end;
  logic [15:0] rec_data_num;
  logic [2:0]  dbg_state;

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  ip_udp_rx_nibble dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .eth_rxdv     (eth_rxdv),
    .eth_rx_data  (eth_rx_data),
    .rec_data_en  (rec_data_en),
    .rec_data     (rec_data),
    .rec_end      (rec_end),
    .rec_data_num (rec_data_num),
    .dbg_state    (dbg_state)
  );

  typedef struct {
    logic [47:0] mac;
    logic [31:0] ip;
    logic [15:0] etype;
    logic [7:0]  sfd;
    int          len;
    bit          accept;
  } vec_t;

  vec_t        vecs[NV];
  int          total = 0;
  int          bad   = 0;
  int          last_num = 0;
  logic [32:0] exp_q[$];
  logic [7:0]  frm[$];
  logic [32:0] mon_e;

  function automatic vec_t mk(input logic [47:0] mac, input logic [31:0] ip,
                              input logic [15:0] etype, input logic [7:0] sfd,
                              input int len, input bit accept);
    vec_t v;
    v.mac = mac; v.ip = ip; v.etype = etype; v.sfd = sfd; v.len = len; v.accept = accept;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic build_frame(input vec_t v);
    logic [15:0] tl;
    logic [15:0] ul;
    tl = 16'(28 + v.len);
    ul = 16'(8 + v.len);
    frm.delete();
    repeat (7) frm.push_back(8'h55);
    frm.push_back(v.sfd);
    for (int i = 0; i < 6; i++) frm.push_back(v.mac[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(SRC_MAC[47-8*i -: 8]);
    frm.push_back(v.etype[15:8]);
    frm.push_back(v.etype[7:0]);
    frm.push_back(8'h45); frm.push_back(8'h00);
    frm.push_back(tl[15:8]); frm.push_back(tl[7:0]);
    frm.push_back(8'h00); frm.push_back(8'h01); frm.push_back(8'h40); frm.push_back(8'h00);
    frm.push_back(8'h40); frm.push_back(8'h11); frm.push_back(8'h00); frm.push_back(8'h00);
    for (int i = 0; i < 4; i++) frm.push_back(SRC_IP[31-8*i -: 8]);
    for (int i = 0; i < 4; i++) frm.push_back(v.ip[31-8*i -: 8]);
    frm.push_back(8'h04); frm.push_back(8'hD2); frm.push_back(8'h16); frm.push_back(8'h2E);
    frm.push_back(ul[15:8]); frm.push_back(ul[7:0]); frm.push_back(8'h00); frm.push_back(8'h00);
    for (int i = 0; i < v.len; i++) frm.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < 4; i++) frm.push_back(8'($urandom_range(0, 255)));
  endtask

  // complete=1: all words incl. zero-padded tail, end on last; else only full words.
  task automatic push_exp(input int nbytes, input bit complete);
    int nw;
    logic [31:0] w;
    nw = complete ? (nbytes + 3) / 4 : nbytes / 4;
    for (int wi = 0; wi < nw; wi++) begin
      w = '0;
      for (int b = 0; b < 4; b++)
        if (wi * 4 + b < nbytes) w[31-8*b -: 8] = frm[PAY_OFS + wi*4 + b];
      exp_q.push_back({(complete && wi == nw - 1), w});
    end
  endtask

  task automatic pulse_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    chk("rst rec_data_en", rec_data_en, 0);
    chk("rst rec_end", rec_end, 0);
    chk("rst rec_data", rec_data, 0);
    chk("rst rec_data_num", rec_data_num, 0);
    chk("rst state", dbg_state, 0);
    #1;
    sys_rst_n = 1'b1;
  endtask

  task automatic send_frame(input int stop_at, input int rst_at);
    logic [7:0] b;
    for (int i = 0; i < frm.size(); i++) begin
      if (i == stop_at) break;
      if (i == rst_at) pulse_reset();
      b = frm[i];
      @(negedge sys_clk);
      eth_rxdv    = 1'b1;
      eth_rx_data = b[3:0];
      @(negedge sys_clk);
      eth_rx_data = b[7:4];
    end
    @(negedge sys_clk);
    eth_rxdv    = 1'b0;
    eth_rx_data = 4'h0;
    repeat (6) @(negedge sys_clk);
  endtask

  task automatic end_of_frame(input string name);
    chk({name, " pending words"}, exp_q.size(), 0);
    exp_q.delete();
    chk({name, " rec_data_num"}, rec_data_num, last_num);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge sys_clk) begin
    if (rec_data_en) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected word: got %08h end=%0d expected none", rec_data, rec_end);
      end else begin
        mon_e = exp_q.pop_front();
        chk("word data", rec_data, mon_e[31:0]);
        chk("word end", rec_end, mon_e[32]);
      end
    end else if (rec_end) begin
      total++;
      bad++;
      $display("FAIL stray rec_end: got 1 expected 0 without rec_data_en");
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    vecs[0]  = mk(BOARD_MAC, BOARD_IP, 16'h0800, 8'hD5, 32, 1'b1);
    vecs[1]  = mk(BOARD_MAC, BOARD_IP, 16'h0800, 8'hD5, 30, 1'b1);
    vecs[2]  = mk(48'h12_34_56_78_9A_BD, BOARD_IP, 16'h0800, 8'hD5, 32, 1'b0);
    vecs[3]  = mk(BOARD_MAC, {8'd169, 8'd254, 8'd1, 8'd24}, 16'h0800, 8'hD5, 32, 1'b0);
    vecs[4]  = mk(BOARD_MAC, BOARD_IP, 16'h0800, 8'hD5, 5, 1'b1);
    vecs[5]  = mk(48'hFFFF_FFFF_FFFF, BOARD_IP, 16'h0800, 8'hD5, 32, 1'b1);
    vecs[6]  = mk(BOARD_MAC, BOARD_IP, 16'h0800, 8'h55, 32, 1'b0);
    vecs[7]  = mk(BOARD_MAC, BOARD_IP, 16'h0806, 8'hD5, 32, 1'b0);
    vecs[8]  = mk(BOARD_MAC, BOARD_IP, 16'h0800, 8'hD5, 0, 1'b1);
    vecs[9]  = mk(BOARD_MAC, BOARD_IP, 16'h0800, 8'hD5, 1, 1'b1);
    vecs[10] = mk(BOARD_MAC, BOARD_IP, 16'h0800, 8'hD5, 4, 1'b1);
    vecs[11] = mk(BOARD_MAC, BOARD_IP, 16'h0800, 8'hD5, $urandom_range(6, 47), 1'b1);

    sys_rst_n   = 1'b0;
    eth_rxdv    = 1'b0;
    eth_rx_data = 4'h0;
    repeat (3) @(negedge sys_clk);
    chk("reset rec_data_en", rec_data_en, 0);
    chk("reset rec_end", rec_end, 0);
    chk("reset rec_data", rec_data, 0);
    chk("reset rec_data_num", rec_data_num, 0);
    chk("reset state", dbg_state, 0);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);

    for (int t = 0; t < NV; t++) begin
      build_frame(vecs[t]);
      if (vecs[t].accept) begin
        push_exp(vecs[t].len, 1'b1);
        last_num = vecs[t].len;
      end
      send_frame(-1, -1);
      end_of_frame($sformatf("vec%0d", t));
    end

    // rxdv drops after 10 payload bytes: two full words, no end, count kept.
    build_frame(vecs[0]);
    push_exp(8, 1'b0);
    last_num = 32;
    send_frame(PAY_OFS + 10, -1);
    end_of_frame("rxdv abort");

    build_frame(vecs[4]);
    push_exp(vecs[4].len, 1'b1);
    last_num = vecs[4].len;
    send_frame(-1, -1);
    end_of_frame("after abort");

    // Reset after 10 payload bytes; the rest of that frame must be ignored.
    build_frame(vecs[0]);
    push_exp(8, 1'b0);
    send_frame(-1, PAY_OFS + 10);
    last_num = 0;
    end_of_frame("reset abort");

    build_frame(vecs[1]);
    push_exp(vecs[1].len, 1'b1);
    last_num = vecs[1].len;
    send_frame(-1, -1);
    end_of_frame("after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
